// File: rtl/pkt_pkg.sv
// pkt_pkg: shared beat type, distributor FSM states and default widths
package pkt_pkg;
    localparam int DEF_DWIDTH = 512;
    localparam int DEF_EWIDTH = 6;

    typedef struct packed {
        logic [DEF_DWIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [DEF_EWIDTH-1:0] empty;
    } pkt_beat_t;

    typedef enum logic {IDLE, LOCKED} dist_state_t;
endpackage

// File: rtl/pkt_distributor_if.sv
// pkt_distributor_if: input Avalon-ST stream, NUM_OUT output lanes and drop counter
interface pkt_distributor_if
    import pkt_pkg::*;
#(
    parameter int NUM_OUT = 2,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int EWIDTH  = DEF_EWIDTH
);
    logic [DWIDTH-1:0]         in_data;
    logic                      in_valid;
    logic                      in_sop;
    logic                      in_eop;
    logic [EWIDTH-1:0]         in_empty;
    logic                      in_ready;
    logic [NUM_OUT*DWIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]        out_valid;
    logic [NUM_OUT-1:0]        out_sop;
    logic [NUM_OUT-1:0]        out_eop;
    logic [NUM_OUT*EWIDTH-1:0] out_empty;
    logic [NUM_OUT-1:0]        out_ready;
    logic [31:0]               drop_cnt;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty, drop_cnt
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_empty, drop_cnt
    );
endinterface

// File: rtl/pkt_out_slot.sv
// pkt_out_slot: one-entry registered output stage for a single lane
module pkt_out_slot
    import pkt_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int EWIDTH = DEF_EWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_sop,
    input  logic              i_eop,
    input  logic [EWIDTH-1:0] i_empty,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic              o_sop,
    output logic              o_eop,
    output logic [EWIDTH-1:0] o_empty,
    output logic              o_free
);
    logic              r_valid;
    logic [DWIDTH-1:0] r_data;
    logic              r_sop;
    logic              r_eop;
    logic [EWIDTH-1:0] r_empty;

    assign o_free  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;
    assign o_empty = r_empty;

    // A load always wins over an unload, so a same-cycle drain and refill keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_sop   <= i_sop;
            r_eop   <= i_eop;
            r_empty <= i_empty;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/pkt_distributor.sv
// pkt_distributor: packet-locked round-robin demux spreading whole packets over NUM_OUT lanes
module pkt_distributor
    import pkt_pkg::*;
#(
    parameter int NUM_OUT = 2,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int EWIDTH  = DEF_EWIDTH
) (
    input  logic             clk,
    input  logic             rst,
    pkt_distributor_if.slave bus
);
    localparam int PW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    dist_state_t               r_state;
    logic [PW-1:0]             r_ptr;
    logic [PW-1:0]             r_lock_sel;
    logic [31:0]               r_drop_cnt;
    logic [NUM_OUT-1:0]        w_free;
    logic [NUM_OUT-1:0]        w_load;
    logic [NUM_OUT-1:0]        w_valid;
    logic [NUM_OUT-1:0]        w_sop;
    logic [NUM_OUT-1:0]        w_eop;
    logic [NUM_OUT*DWIDTH-1:0] w_data;
    logic [NUM_OUT*EWIDTH-1:0] w_empty;
    logic                      w_found;
    logic                      w_ready;
    logic                      w_accept;
    logic                      w_orphan;
    logic                      w_err;
    logic                      w_fwd;
    logic                      w_sop_in;
    logic [PW-1:0]             w_target;
    logic [PW-1:0]             w_sel;

    // First free lane at or after ptr, wrapping; MSB of the result flags a hit.
    function automatic logic [PW:0] find_lane(input logic [NUM_OUT-1:0] free, input logic [PW-1:0] ptr);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_OUT;
            if (free[idx]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] next_lane(input logic [PW-1:0] p);
        return (int'(p) == NUM_OUT - 1) ? '0 : p + 1'b1;
    endfunction

    assign {w_found, w_target} = find_lane(w_free, r_ptr);
    assign w_sel    = (r_state == LOCKED) ? r_lock_sel : w_target;
    assign w_ready  = rst ? 1'b0 : (r_state == LOCKED) ? w_free[r_lock_sel] : (bus.in_sop ? w_found : 1'b1);
    assign w_accept = bus.in_valid & w_ready;
    assign w_orphan = w_accept & (r_state == IDLE) & ~bus.in_sop;
    assign w_err    = w_accept & (r_state == LOCKED) & bus.in_sop;
    assign w_fwd    = w_accept & ~w_orphan;
    // A stray sop inside a locked packet is forwarded as a plain data beat.
    assign w_sop_in = bus.in_sop & (r_state == IDLE);

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_data;
    assign bus.out_sop   = w_sop;
    assign bus.out_eop   = w_eop;
    assign bus.out_empty = w_empty;
    assign bus.drop_cnt  = r_drop_cnt;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        assign w_load[i] = w_fwd & (w_sel == PW'(i));
        pkt_out_slot #(.DWIDTH(DWIDTH), .EWIDTH(EWIDTH)) u_slot (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[i]),
            .i_data (bus.in_data),
            .i_sop  (w_sop_in),
            .i_eop  (bus.in_eop),
            .i_empty(bus.in_empty),
            .i_ready(bus.out_ready[i]),
            .o_valid(w_valid[i]),
            .o_data (w_data[i*DWIDTH +: DWIDTH]),
            .o_sop  (w_sop[i]),
            .o_eop  (w_eop[i]),
            .o_empty(w_empty[i*EWIDTH +: EWIDTH]),
            .o_free (w_free[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_lock_sel <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_fwd && r_state == IDLE && bus.in_eop) begin
                r_ptr <= next_lane(w_target);
            end else if (w_fwd && r_state == IDLE) begin
                r_lock_sel <= w_target;
                r_state    <= LOCKED;
            end else if (w_fwd && bus.in_eop) begin
                r_state <= IDLE;
                r_ptr   <= next_lane(r_lock_sel);
            end
            if ((w_orphan | w_err) && r_drop_cnt != '1)
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end
endmodule
